// File: rtl/dsp_adc_rx_pkg.sv
// Shared constants and types for the ADC receive path: register map,
// receive FSM states and status-word bit positions.
package dsp_adc_rx_pkg;

    localparam int unsigned DEF_RX_DATA_ADDR = 9;
    localparam int unsigned DEF_RX_STAT_ADDR = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } rx_state_t;

    localparam int STAT_RUN  = 0;
    localparam int STAT_FILL = 1;
    localparam int STAT_OVF  = 2;
    localparam int STAT_UDF  = 3;

endpackage

// File: rtl/dsp_adc_rx_if.sv
// RX FIFO ports (write and read side) plus the host register read bus.
// The receive block uses the slave view; whoever models FIFO and host uses master.
interface dsp_adc_rx_if #(
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    // FIFO handshake: a strobe is a one-cycle request with no back-pressure;
    // the FIFO state is reported through i_full_rx / i_empty_rx only.
    logic                  i_full_rx;
    logic                  i_empty_rx;
    logic                  o_w_inc_rx;
    logic [BUS_WIDTH-1:0]  o_w_data_rx;
    logic [BUS_WIDTH-1:0]  i_rd_data_rx;
    logic                  o_rd_inc_rx;
    logic                  i_vaild_reg;
    logic [DATA_WIDTH-1:0] i_address_reg;
    logic                  o_rd_valid;
    logic [BUS_WIDTH-1:0]  o_rd_data;

    modport slave (
        input  i_full_rx, i_empty_rx, i_rd_data_rx, i_vaild_reg, i_address_reg,
        output o_w_inc_rx, o_w_data_rx, o_rd_inc_rx, o_rd_valid, o_rd_data
    );

    modport master (
        output i_full_rx, i_empty_rx, i_rd_data_rx, i_vaild_reg, i_address_reg,
        input  o_w_inc_rx, o_w_data_rx, o_rd_inc_rx, o_rd_valid, o_rd_data
    );

endinterface

// File: rtl/dsp_adc_rx_moving_avg_core.sv
// Moving-average core: tap line and running sum. The result for an accepted
// sample is combinational so the caller can register it alongside its own gating.
module moving_avg_core #(
    parameter int unsigned BUS_WIDTH = 8,
    parameter int unsigned TAP_SIZE  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_in_valid,
    input  logic [BUS_WIDTH-1:0] i_in_data,
    output logic                 o_out_valid,
    output logic [BUS_WIDTH-1:0] o_out_data
);

    localparam int unsigned LOG2  = $clog2(TAP_SIZE);
    localparam int unsigned SUM_W = BUS_WIDTH + LOG2;
    localparam int unsigned CNT_W = $clog2(TAP_SIZE + 1);

    logic [BUS_WIDTH-1:0] r_taps [TAP_SIZE];
    logic [SUM_W-1:0]     r_sum;
    logic [CNT_W-1:0]     r_count;
    logic [SUM_W-1:0]     w_next_sum;
    logic                 w_window_full;

    // Unfilled taps hold zero, so subtracting the oldest tap is always correct.
    assign w_next_sum    = r_sum + SUM_W'(i_in_data) - SUM_W'(r_taps[TAP_SIZE-1]);
    assign w_window_full = (r_count >= CNT_W'(TAP_SIZE - 1));
    assign o_out_valid   = i_in_valid && !i_clear && w_window_full;
    assign o_out_data    = w_next_sum[SUM_W-1:LOG2];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            for (int i = 0; i < TAP_SIZE; i++) r_taps[i] <= '0;
            r_sum   <= '0;
            r_count <= '0;
        end else if (i_in_valid) begin
            r_taps[0] <= i_in_data;
            for (int i = 1; i < TAP_SIZE; i++) r_taps[i] <= r_taps[i-1];
            r_sum <= w_next_sum;
            if (r_count != CNT_W'(TAP_SIZE)) r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dsp_adc_rx.sv
// ADC receive path: gates samples through the fill/run FSM into the moving
// average, pushes results to the RX FIFO and serves host data/status reads.
module dsp_adc_rx
    import dsp_adc_rx_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned TAP_SIZE     = 4,
    parameter int unsigned RX_DATA_ADDR = DEF_RX_DATA_ADDR,
    parameter int unsigned RX_STAT_ADDR = DEF_RX_STAT_ADDR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode_sel_rx,
    input  logic                 i_adc_valid,
    input  logic [BUS_WIDTH-1:0] i_adc_data,
    dsp_adc_rx_if.slave          bus,
    output logic [3:0]           dsp_stat_rx,
    output logic [1:0]           fifo_level_rx,
    output logic [7:0]           o_ovf_count,
    output rx_state_t            o_dbg_state
);

    rx_state_t            r_state;
    rx_state_t            w_next_state;
    logic                 r_w_inc;
    logic [BUS_WIDTH-1:0] r_w_data;
    logic                 r_rd_inc;
    logic                 r_rd_valid;
    logic [BUS_WIDTH-1:0] r_rd_data;
    logic                 r_ovf;
    logic                 r_udf;
    logic [7:0]           r_ovf_cnt;

    logic                 w_accept;
    logic                 w_clear;
    logic                 w_core_valid;
    logic [BUS_WIDTH-1:0] w_core_data;
    logic                 w_ovf_event;
    logic                 w_data_rd;
    logic                 w_stat_rd;
    logic                 w_udf_event;

    // A sample arriving while the mode bit drops is discarded along with the taps.
    assign w_accept    = i_adc_valid && mode_sel_rx && (r_state != IDLE);
    assign w_clear     = !mode_sel_rx;
    assign w_ovf_event = w_core_valid && bus.i_full_rx;
    assign w_data_rd   = bus.i_vaild_reg && (bus.i_address_reg == DATA_WIDTH'(RX_DATA_ADDR));
    assign w_stat_rd   = bus.i_vaild_reg && (bus.i_address_reg == DATA_WIDTH'(RX_STAT_ADDR));
    assign w_udf_event = w_data_rd && bus.i_empty_rx;

    moving_avg_core #(
        .BUS_WIDTH (BUS_WIDTH),
        .TAP_SIZE  (TAP_SIZE)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_in_valid  (w_accept),
        .i_in_data   (i_adc_data),
        .o_out_valid (w_core_valid),
        .o_out_data  (w_core_data)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // The sample that completes the window yields the first result and moves to RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (mode_sel_rx) w_next_state = FILL;
            FILL:    if (!mode_sel_rx) w_next_state = IDLE;
                     else if (w_core_valid) w_next_state = RUN;
            RUN:     if (!mode_sel_rx) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_inc  <= 1'b0;
            r_w_data <= '0;
        end else begin
            r_w_inc <= w_core_valid && !bus.i_full_rx;
            if (w_core_valid && !bus.i_full_rx) r_w_data <= w_core_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_inc   <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_inc   <= 1'b0;
            r_rd_valid <= 1'b0;
            if (w_data_rd) begin
                r_rd_valid <= 1'b1;
                if (!bus.i_empty_rx) begin
                    r_rd_inc  <= 1'b1;
                    r_rd_data <= bus.i_rd_data_rx;
                end else begin
                    r_rd_data <= '0;
                end
            end else if (w_stat_rd) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= BUS_WIDTH'(dsp_stat_rx);
            end
        end
    end

    // A status read clears the sticky state, but an event in that same cycle survives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_ovf_cnt <= '0;
        end else if (w_stat_rd) begin
            r_ovf     <= w_ovf_event;
            r_udf     <= w_udf_event;
            r_ovf_cnt <= w_ovf_event ? 8'd1 : 8'd0;
        end else begin
            if (w_ovf_event) begin
                r_ovf <= 1'b1;
                if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
            if (w_udf_event) r_udf <= 1'b1;
        end
    end

    always_comb begin
        dsp_stat_rx           = '0;
        dsp_stat_rx[STAT_RUN]  = (r_state == RUN);
        dsp_stat_rx[STAT_FILL] = (r_state == FILL);
        dsp_stat_rx[STAT_OVF]  = r_ovf;
        dsp_stat_rx[STAT_UDF]  = r_udf;
    end

    assign fifo_level_rx   = {bus.i_empty_rx, bus.i_full_rx};
    assign o_ovf_count     = r_ovf_cnt;
    assign o_dbg_state     = r_state;
    assign bus.o_w_inc_rx  = r_w_inc;
    assign bus.o_w_data_rx = r_w_data;
    assign bus.o_rd_inc_rx = r_rd_inc;
    assign bus.o_rd_valid  = r_rd_valid;
    assign bus.o_rd_data   = r_rd_data;

endmodule

// File: tb/tb_dsp_adc_rx.sv
// Directed bench for dsp_adc_rx: filter arithmetic, FIFO overflow, host reads,
// mode drop and reset abort, each step checked against hand-computed values.
module tb_dsp_adc_rx;
    import dsp_adc_rx_pkg::*;

    logic       clk;
    logic       rst;
    logic       mode_sel_rx;
    logic       i_adc_valid;
    logic [7:0] i_adc_data;
    logic [3:0] dsp_stat_rx;
    logic [1:0] fifo_level_rx;
    logic [7:0] o_ovf_count;
    rx_state_t  o_dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic any_winc;

    dsp_adc_rx_if #(.BUS_WIDTH(8), .DATA_WIDTH(32)) bus ();

    dsp_adc_rx #(
        .BUS_WIDTH (8),
        .DATA_WIDTH(32),
        .TAP_SIZE  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_sel_rx  (mode_sel_rx),
        .i_adc_valid  (i_adc_valid),
        .i_adc_data   (i_adc_data),
        .bus          (bus),
        .dsp_stat_rx  (dsp_stat_rx),
        .fifo_level_rx(fifo_level_rx),
        .o_ovf_count  (o_ovf_count),
        .o_dbg_state  (o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sample(input logic [7:0] v);
        i_adc_valid = 1'b1;
        i_adc_data  = v;
        tick();
        i_adc_valid = 1'b0;
    endtask

    task automatic host_read(input logic [31:0] addr);
        bus.i_vaild_reg   = 1'b1;
        bus.i_address_reg = addr;
        tick();
        bus.i_vaild_reg   = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        mode_sel_rx       = 1'b0;
        i_adc_valid       = 1'b0;
        i_adc_data        = '0;
        bus.i_full_rx     = 1'b0;
        bus.i_empty_rx    = 1'b1;
        bus.i_rd_data_rx  = '0;
        bus.i_vaild_reg   = 1'b0;
        bus.i_address_reg = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_w_inc", 32'(bus.o_w_inc_rx), 0);
        check("rst_rd_valid", 32'(bus.o_rd_valid), 0);
        check("rst_rd_data", 32'(bus.o_rd_data), 0);
        check("rst_stat", 32'(dsp_stat_rx), 0);
        check("rst_ovf_cnt", 32'(o_ovf_count), 0);
        check("rst_fifo_level", 32'(fifo_level_rx), 32'h2);
        check("rst_state", 32'(o_dbg_state), 32'(IDLE));

        // Fill with 10,20,30,40 then 50
        mode_sel_rx = 1'b1;
        tick();
        check("fill_state", 32'(o_dbg_state), 32'(FILL));
        check("fill_stat", 32'(dsp_stat_rx), 32'h2);
        push_sample(8'd10);
        check("fill_no_w1", 32'(bus.o_w_inc_rx), 0);
        push_sample(8'd20);
        check("fill_no_w2", 32'(bus.o_w_inc_rx), 0);
        push_sample(8'd30);
        check("fill_no_w3", 32'(bus.o_w_inc_rx), 0);
        push_sample(8'd40);
        check("first_w_inc", 32'(bus.o_w_inc_rx), 1);
        check("first_w_data", 32'(bus.o_w_data_rx), 25);
        check("run_state", 32'(o_dbg_state), 32'(RUN));
        tick();
        check("w_inc_pulse", 32'(bus.o_w_inc_rx), 0);
        push_sample(8'd50);
        check("second_w_inc", 32'(bus.o_w_inc_rx), 1);
        check("second_w_data", 32'(bus.o_w_data_rx), 35);

        // Truncation and full-scale samples
        push_sample(8'd1);
        check("mix_w_data", 32'(bus.o_w_data_rx), 30);
        push_sample(8'd1);
        push_sample(8'd1);
        push_sample(8'd2);
        check("trunc_w_data", 32'(bus.o_w_data_rx), 1);
        push_sample(8'd255);
        check("ramp_w_data", 32'(bus.o_w_data_rx), 64);
        push_sample(8'd255);
        push_sample(8'd255);
        push_sample(8'd255);
        check("max_w_data", 32'(bus.o_w_data_rx), 255);
        check("max_ovf_cnt", 32'(o_ovf_count), 0);

        // FIFO full over 300 results
        bus.i_full_rx = 1'b1;
        any_winc = 1'b0;
        for (int i = 0; i < 300; i++) begin
            push_sample(8'd7);
            any_winc = any_winc | bus.o_w_inc_rx;
        end
        check("full_no_w_inc", 32'(any_winc), 0);
        check("full_ovf_cnt", 32'(o_ovf_count), 255);
        check("full_ovf_flag", 32'(dsp_stat_rx[2]), 1);
        check("full_fifo_level", 32'(fifo_level_rx), 32'h3);
        bus.i_full_rx = 1'b0;
        host_read(32'd10);
        check("stat_rd_valid", 32'(bus.o_rd_valid), 1);
        check("stat_rd_data", 32'(bus.o_rd_data), 32'h05);
        check("stat_clr_cnt", 32'(o_ovf_count), 0);
        check("stat_clr_flag", 32'(dsp_stat_rx[2]), 0);
        tick();
        check("stat_rd_pulse", 32'(bus.o_rd_valid), 0);

        // Overflow in the same cycle as a status read
        bus.i_full_rx     = 1'b1;
        i_adc_valid       = 1'b1;
        i_adc_data        = 8'd7;
        bus.i_vaild_reg   = 1'b1;
        bus.i_address_reg = 32'd10;
        tick();
        i_adc_valid     = 1'b0;
        bus.i_vaild_reg = 1'b0;
        bus.i_full_rx   = 1'b0;
        check("setwins_rd_data", 32'(bus.o_rd_data), 32'h01);
        check("setwins_cnt", 32'(o_ovf_count), 1);
        check("setwins_flag", 32'(dsp_stat_rx[2]), 1);
        check("setwins_no_w", 32'(bus.o_w_inc_rx), 0);
        host_read(32'd10);
        check("stat2_rd_data", 32'(bus.o_rd_data), 32'h05);
        check("stat2_cnt", 32'(o_ovf_count), 0);

        // Data reads: non-empty, empty, unmapped address
        bus.i_empty_rx   = 1'b0;
        bus.i_rd_data_rx = 8'hA5;
        host_read(32'd9);
        check("pop_rd_inc", 32'(bus.o_rd_inc_rx), 1);
        check("pop_rd_valid", 32'(bus.o_rd_valid), 1);
        check("pop_rd_data", 32'(bus.o_rd_data), 32'hA5);
        tick();
        check("pop_rd_inc_pulse", 32'(bus.o_rd_inc_rx), 0);
        check("pop_rd_valid_pulse", 32'(bus.o_rd_valid), 0);
        bus.i_empty_rx = 1'b1;
        host_read(32'd9);
        check("udf_rd_inc", 32'(bus.o_rd_inc_rx), 0);
        check("udf_rd_valid", 32'(bus.o_rd_valid), 1);
        check("udf_rd_data", 32'(bus.o_rd_data), 0);
        check("udf_flag", 32'(dsp_stat_rx[3]), 1);
        host_read(32'd5);
        check("other_addr_valid", 32'(bus.o_rd_valid), 0);

        // Same-cycle push and pop
        bus.i_empty_rx    = 1'b0;
        bus.i_rd_data_rx  = 8'h3C;
        i_adc_valid       = 1'b1;
        i_adc_data        = 8'd11;
        bus.i_vaild_reg   = 1'b1;
        bus.i_address_reg = 32'd9;
        tick();
        i_adc_valid     = 1'b0;
        bus.i_vaild_reg = 1'b0;
        check("both_w_inc", 32'(bus.o_w_inc_rx), 1);
        check("both_w_data", 32'(bus.o_w_data_rx), 8);
        check("both_rd_inc", 32'(bus.o_rd_inc_rx), 1);
        check("both_rd_data", 32'(bus.o_rd_data), 32'h3C);

        // Mode drop with a coincident sample, then refill
        mode_sel_rx = 1'b0;
        push_sample(8'd200);
        check("drop_state", 32'(o_dbg_state), 32'(IDLE));
        check("drop_no_w", 32'(bus.o_w_inc_rx), 0);
        mode_sel_rx = 1'b1;
        tick();
        check("refill_state", 32'(o_dbg_state), 32'(FILL));
        push_sample(8'd100);
        push_sample(8'd100);
        push_sample(8'd100);
        check("refill_no_w", 32'(bus.o_w_inc_rx), 0);
        push_sample(8'd104);
        check("refill_w_inc", 32'(bus.o_w_inc_rx), 1);
        check("refill_w_data", 32'(bus.o_w_data_rx), 101);

        // Reset with a write and a pop in flight
        bus.i_full_rx = 1'b1;
        push_sample(8'd104);
        bus.i_full_rx = 1'b0;
        check("pre_rst_cnt", 32'(o_ovf_count), 1);
        i_adc_valid       = 1'b1;
        i_adc_data        = 8'd50;
        bus.i_vaild_reg   = 1'b1;
        bus.i_address_reg = 32'd9;
        tick();
        i_adc_valid     = 1'b0;
        bus.i_vaild_reg = 1'b0;
        check("inflight_w_inc", 32'(bus.o_w_inc_rx), 1);
        check("inflight_rd_inc", 32'(bus.o_rd_inc_rx), 1);
        rst = 1'b1;
        tick();
        check("abort_w_inc", 32'(bus.o_w_inc_rx), 0);
        check("abort_rd_inc", 32'(bus.o_rd_inc_rx), 0);
        check("abort_rd_valid", 32'(bus.o_rd_valid), 0);
        check("abort_state", 32'(o_dbg_state), 32'(IDLE));
        check("abort_cnt", 32'(o_ovf_count), 0);
        check("abort_stat", 32'(dsp_stat_rx), 0);
        rst = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
